// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and counter sizing for the PLL lock supervisor.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_PWRDN     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_FILTER    = 3'd3,
        S_RELEASE   = 3'd4,
        S_RUN       = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    // Bits needed to hold 0..limit; never narrower than one bit.
    function automatic int cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser with asynchronous active-low reset to 0.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL supervisor: power sequencing, lock filtering, staggered domain reset
// release, lock-loss retry and fault latching, all on the reference clock.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int PD_CYCLES    = 16,
    parameter int LOCK_FILT    = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int STAGGER      = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic                         CLKA,
    input  logic                         RESETN,
    input  logic                         EN,
    input  logic                         CLR_FAULT,
    input  logic                         LOCK_RAW,
    output logic                         PLL_PD_N,
    output logic [N_CH-1:0]              CH_RST_N,
    output logic                         LOCKED,
    output logic                         FAULT,
    output logic [cnt_w(MAX_RETRY)-1:0]  RETRY_CNT,
    output logic [2:0]                   STATE
);

    localparam int PD_W    = cnt_w(PD_CYCLES);
    localparam int FLT_W   = cnt_w(LOCK_FILT);
    localparam int TO_W    = cnt_w(LOCK_TIMEOUT);
    localparam int REL_MAX = (N_CH - 1) * STAGGER;
    localparam int REL_W   = cnt_w(REL_MAX);
    localparam int RT_W    = cnt_w(MAX_RETRY);

    localparam logic [PD_W-1:0]  PD_LAST  = PD_W'(PD_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(LOCK_TIMEOUT);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_MAX);
    localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);

    state_t            state, state_n;
    logic              pd_n, pd_n_n;
    logic [N_CH-1:0]   ch, ch_n;
    logic              locked, locked_n;
    logic              fault, fault_n;
    logic [RT_W-1:0]   retry, retry_n, retry_inc;
    logic [PD_W-1:0]   pd_cnt, pd_cnt_n;
    logic [FLT_W-1:0]  flt_cnt, flt_cnt_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n, to_inc;
    logic [REL_W-1:0]  rel_cnt, rel_cnt_n, rel_inc;
    logic              lock_s, timeout, fail, declare;

    pll_lock_sync u_lock_sync (
        .clk   (CLKA),
        .rst_n (RESETN),
        .d     (LOCK_RAW),
        .q     (lock_s)
    );

    always_ff @(posedge CLKA or negedge RESETN) begin
        if (!RESETN) begin
            state   <= S_OFF;
            pd_n    <= 1'b0;
            ch      <= '0;
            locked  <= 1'b0;
            fault   <= 1'b0;
            retry   <= '0;
            pd_cnt  <= '0;
            flt_cnt <= '0;
            to_cnt  <= '0;
            rel_cnt <= '0;
        end else begin
            state   <= state_n;
            pd_n    <= pd_n_n;
            ch      <= ch_n;
            locked  <= locked_n;
            fault   <= fault_n;
            retry   <= retry_n;
            pd_cnt  <= pd_cnt_n;
            flt_cnt <= flt_cnt_n;
            to_cnt  <= to_cnt_n;
            rel_cnt <= rel_cnt_n;
        end
    end

    // Timeout fires on the edge the counter would reach its limit, so a
    // failed attempt drops PLL_PD_N exactly LOCK_TIMEOUT cycles after it rose.
    assign to_inc    = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;
    assign timeout   = (to_cnt >= TO_LAST);
    assign retry_inc = (retry == RT_MAX) ? retry : retry + 1'b1;
    assign rel_inc   = rel_cnt + 1'b1;

    always_comb begin
        state_n   = state;
        pd_n_n    = pd_n;
        ch_n      = ch;
        locked_n  = locked;
        fault_n   = fault;
        retry_n   = retry;
        pd_cnt_n  = pd_cnt;
        flt_cnt_n = flt_cnt;
        to_cnt_n  = to_cnt;
        rel_cnt_n = rel_cnt;
        fail      = 1'b0;
        declare   = 1'b0;

        case (state)
            S_OFF: begin
                if (EN) begin
                    state_n  = S_PWRDN;
                    pd_cnt_n = '0;
                end
            end
            S_PWRDN: begin
                if (pd_cnt == PD_LAST) begin
                    state_n   = S_WAIT_LOCK;
                    pd_n_n    = 1'b1;
                    to_cnt_n  = '0;
                    flt_cnt_n = '0;
                end else begin
                    pd_cnt_n = pd_cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                to_cnt_n = to_inc;
                if (timeout) begin
                    fail = 1'b1;
                end else if (lock_s) begin
                    if (LOCK_FILT == 1) begin
                        declare = 1'b1;
                    end else begin
                        state_n   = S_FILTER;
                        flt_cnt_n = FLT_W'(1);
                    end
                end
            end
            S_FILTER: begin
                to_cnt_n = to_inc;
                if (timeout) begin
                    fail = 1'b1;
                end else if (!lock_s) begin
                    state_n   = S_WAIT_LOCK;
                    flt_cnt_n = '0;
                end else if (flt_cnt == FLT_LAST) begin
                    declare = 1'b1;
                end else begin
                    flt_cnt_n = flt_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    fail = 1'b1;
                end else if (rel_cnt == REL_LAST) begin
                    state_n = S_RUN;
                end else begin
                    rel_cnt_n = rel_inc;
                    for (int i = 1; i < N_CH; i++) begin
                        if (int'(rel_inc) >= i * STAGGER) ch_n[i] = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!lock_s) fail = 1'b1;
            end
            S_FAULT: begin
                if (CLR_FAULT) begin
                    state_n = S_OFF;
                    fault_n = 1'b0;
                    retry_n = '0;
                end
            end
            default: state_n = S_OFF;
        endcase

        if (declare) begin
            state_n   = (N_CH == 1) ? S_RUN : S_RELEASE;
            locked_n  = 1'b1;
            ch_n[0]   = 1'b1;
            rel_cnt_n = '0;
        end

        if (fail) begin
            ch_n     = '0;
            locked_n = 1'b0;
            pd_n_n   = 1'b0;
            retry_n  = retry_inc;
            pd_cnt_n = '0;
            if (retry_inc == RT_MAX) begin
                state_n = S_FAULT;
                fault_n = 1'b1;
            end else begin
                state_n = S_PWRDN;
            end
        end

        // Dropping the run request overrides every other event except a latched fault.
        if (!EN && state != S_FAULT) begin
            state_n   = S_OFF;
            pd_n_n    = 1'b0;
            ch_n      = '0;
            locked_n  = 1'b0;
            fault_n   = 1'b0;
            retry_n   = '0;
            pd_cnt_n  = '0;
            flt_cnt_n = '0;
            to_cnt_n  = '0;
            rel_cnt_n = '0;
        end
    end

    assign PLL_PD_N  = pd_n;
    assign CH_RST_N  = ch;
    assign LOCKED    = locked;
    assign FAULT     = fault;
    assign RETRY_CNT = retry;
    assign STATE     = state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small parameters; expected values are
// hand-derived cycle counts from the edge where each input changes.
module tb_pll_lock_ctrl;

    logic       CLKA = 1'b0;
    logic       RESETN;
    logic       EN;
    logic       CLR_FAULT;
    logic       LOCK_RAW;
    logic       PLL_PD_N;
    logic [2:0] CH_RST_N;
    logic       LOCKED;
    logic       FAULT;
    logic [1:0] RETRY_CNT;
    logic [2:0] STATE;

    int vectors = 0;
    int errs    = 0;

    pll_lock_ctrl #(
        .N_CH(3), .PD_CYCLES(4), .LOCK_FILT(8),
        .LOCK_TIMEOUT(64), .STAGGER(2), .MAX_RETRY(2)
    ) dut (
        .CLKA      (CLKA),
        .RESETN    (RESETN),
        .EN        (EN),
        .CLR_FAULT (CLR_FAULT),
        .LOCK_RAW  (LOCK_RAW),
        .PLL_PD_N  (PLL_PD_N),
        .CH_RST_N  (CH_RST_N),
        .LOCKED    (LOCKED),
        .FAULT     (FAULT),
        .RETRY_CNT (RETRY_CNT),
        .STATE     (STATE)
    );

    always #5 CLKA = ~CLKA;

    task automatic step(input int n);
        repeat (n) @(posedge CLKA);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pd"}, PLL_PD_N, 0);
        chk({tag, "_ch"}, CH_RST_N, 0);
        chk({tag, "_locked"}, LOCKED, 0);
        chk({tag, "_fault"}, FAULT, 0);
        chk({tag, "_retry"}, RETRY_CNT, 0);
        chk({tag, "_state"}, STATE, 0);
    endtask

    initial begin
        RESETN = 1'b0; EN = 1'b0; CLR_FAULT = 1'b0; LOCK_RAW = 1'b0;
        #3;
        chk_reset_vals("rst");
        step(2);

        // Normal bring-up
        RESETN = 1'b1; EN = 1'b1;
        step(4);  chk("bu_pd_low", PLL_PD_N, 0); chk("bu_pwrdn", STATE, 1);
        step(1);  chk("bu_pd_rise", PLL_PD_N, 1); chk("bu_wait", STATE, 2);
        LOCK_RAW = 1'b1;
        step(9);  chk("bu_nolock", LOCKED, 0); chk("bu_filter", STATE, 3);
        step(1);  chk("bu_locked", LOCKED, 1); chk("bu_ch0", CH_RST_N, 3'b001); chk("bu_release", STATE, 4);
        step(2);  chk("bu_ch1", CH_RST_N, 3'b011);
        step(2);  chk("bu_ch2", CH_RST_N, 3'b111); chk("bu_still_rel", STATE, 4);
        step(1);  chk("bu_run", STATE, 5); chk("bu_retry", RETRY_CNT, 0);

        // Lock loss in RUN, then relock
        LOCK_RAW = 1'b0;
        step(2);  chk("ll_hold_locked", LOCKED, 1); chk("ll_hold_run", STATE, 5);
        step(1);  chk("ll_ch", CH_RST_N, 0); chk("ll_locked", LOCKED, 0);
        chk("ll_pd", PLL_PD_N, 0); chk("ll_retry", RETRY_CNT, 1); chk("ll_state", STATE, 1);
        LOCK_RAW = 1'b1;
        step(4);  chk("rl_pd", PLL_PD_N, 1); chk("rl_wait", STATE, 2);
        step(8);  chk("rl_locked", LOCKED, 1); chk("rl_rel", STATE, 4);
        step(5);  chk("rl_run", STATE, 5); chk("rl_ch", CH_RST_N, 3'b111); chk("rl_retry", RETRY_CNT, 1);

        // EN drop from RUN, then lock glitch at filter count 5
        EN = 1'b0; LOCK_RAW = 1'b0;
        step(1);  chk("en_off", STATE, 0); chk("en_retry", RETRY_CNT, 0);
        chk("en_pd", PLL_PD_N, 0); chk("en_ch", CH_RST_N, 0); chk("en_locked", LOCKED, 0);
        EN = 1'b1;
        step(5);  chk("gl_pd", PLL_PD_N, 1);
        LOCK_RAW = 1'b1;
        step(5);  LOCK_RAW = 1'b0;
        step(1);  LOCK_RAW = 1'b1;
        step(1);  chk("gl_cnt5", STATE, 3);
        step(1);  chk("gl_restart", STATE, 2); chk("gl_nolock", LOCKED, 0);
        step(1);  chk("gl_refilter", STATE, 3);
        step(6);  chk("gl_not_yet", LOCKED, 0); chk("gl_still_flt", STATE, 3);
        step(1);  chk("gl_locked", LOCKED, 1); chk("gl_rel", STATE, 4);
        step(5);  chk("gl_run", STATE, 5);

        // Timeouts with a short lock pulse that must not restart the timeout
        EN = 1'b0; LOCK_RAW = 1'b0;
        step(1);  chk("to_off", STATE, 0);
        EN = 1'b1;
        step(5);  chk("to_pd", PLL_PD_N, 1); chk("to_wait", STATE, 2);
        step(34); LOCK_RAW = 1'b1;
        step(3);  chk("to_pulse_flt", STATE, 3); LOCK_RAW = 1'b0;
        step(3);  chk("to_pulse_back", STATE, 2);
        step(23); chk("to1_pd_hold", PLL_PD_N, 1); chk("to1_state_hold", STATE, 2); chk("to1_retry_hold", RETRY_CNT, 0);
        step(1);  chk("to1_pd", PLL_PD_N, 0); chk("to1_state", STATE, 1); chk("to1_retry", RETRY_CNT, 1);
        step(4);  chk("to2_pd_rise", PLL_PD_N, 1);
        step(63); chk("to2_state_hold", STATE, 2);
        step(1);  chk("to2_fault", FAULT, 1); chk("to2_state", STATE, 6);
        chk("to2_retry", RETRY_CNT, 2); chk("to2_pd", PLL_PD_N, 0); chk("to2_ch", CH_RST_N, 0);
        EN = 1'b0; step(2); EN = 1'b1; step(2); EN = 1'b0; step(2);
        chk("flt_sticky_state", STATE, 6); chk("flt_sticky", FAULT, 1); chk("flt_pd", PLL_PD_N, 0);

        // FAULT recovery and restart
        CLR_FAULT = 1'b1;
        step(1);  chk("clr_state", STATE, 0); chk("clr_fault", FAULT, 0); chk("clr_retry", RETRY_CNT, 0);
        CLR_FAULT = 1'b0;
        step(2);  chk("clr_idle", STATE, 0);
        EN = 1'b1; LOCK_RAW = 1'b1;
        step(5);  chk("rs_pd", PLL_PD_N, 1); chk("rs_wait", STATE, 2);
        step(8);  chk("rs_locked", LOCKED, 1); chk("rs_ch0", CH_RST_N, 3'b001); chk("rs_rel", STATE, 4);
        step(1);  chk("rs_mid_rel", STATE, 4);

        // Asynchronous reset mid-RELEASE, no clock edge
        RESETN = 1'b0;
        #2;
        chk_reset_vals("arst");

        // EN dropped on the edge lock would be declared
        step(1);
        RESETN = 1'b1;
        step(5);  chk("ed_pd", PLL_PD_N, 1);
        step(7);  chk("ed_filter", STATE, 3); chk("ed_nolock", LOCKED, 0);
        EN = 1'b0;
        step(1);  chk("ed_off", STATE, 0); chk("ed_locked", LOCKED, 0);
        chk("ed_pd_off", PLL_PD_N, 0); chk("ed_ch", CH_RST_N, 0);
        step(3);  chk("ed_never", LOCKED, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
